// File: rtl/alarm_controller.sv
// alarm_controller: programmable BCD alarm with edge-triggered match, snooze, stop and ring timeout
module alarm_controller #(
   parameter int RING_TICKS  = 60,
   parameter int SNOOZE_MINS = 5,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] time_now,
   input  logic        tick,
   input  logic        alarm_on,
   input  logic        set_alarm,
   input  logic [12:0] set_value,
   input  logic        snooze,
   input  logic        stop,
   output logic [12:0] alarm_time,
   output logic        ringing,
   output logic        snoozed,
   output logic        set_err,
   output logic [1:0]  state
);
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RING = 2'd2, SNOOZE = 2'd3} state_t;
   state_t      st, st_nx;
   logic [12:0] snooze_time, alarm_nx, snooze_nx, snooze_calc;
   logic [7:0]  ring_cnt, ring_nx;
   logic [2:0]  snooze_cnt, scnt_nx;
   logic        eq_prev, eqp_nx, err_nx, eq, hit, carry;
   logic [6:0]  m_sum, m_new, h_cur, h_new;
   function automatic logic valid_time(input logic [12:0] t);
      return t[12:11] <= 2'd2 && t[10:7] <= 4'd9 && !(t[12:11] == 2'd2 && t[10:7] > 4'd3)
             && t[6:4] <= 3'd5 && t[3:0] <= 4'd9;
   endfunction
   assign eq  = time_now == (st == SNOOZE ? snooze_time : alarm_time);
   assign hit = eq & ~eq_prev;
   // Snooze target: minutes and hours handled in binary, then re-encoded as BCD
   always_comb begin
      m_sum = {4'd0, time_now[6:4]} * 7'd10 + {3'd0, time_now[3:0]} + 7'(SNOOZE_MINS);
      carry = m_sum >= 7'd60;
      m_new = carry ? m_sum - 7'd60 : m_sum;
      h_cur = {5'd0, time_now[12:11]} * 7'd10 + {3'd0, time_now[10:7]};
      h_new = !carry ? h_cur : h_cur == 7'd23 ? 7'd0 : h_cur + 7'd1;
      snooze_calc = {2'(h_new / 7'd10), 4'(h_new % 7'd10), 3'(m_new / 7'd10), 4'(m_new % 7'd10)};
   end
   always_comb begin
      st_nx     = st;
      alarm_nx  = alarm_time;
      snooze_nx = snooze_time;
      ring_nx   = ring_cnt;
      scnt_nx   = snooze_cnt;
      eqp_nx    = eq;
      err_nx    = 1'b0;
      if (set_alarm) begin
         if (valid_time(set_value)) begin
            alarm_nx = set_value;
            eqp_nx   = 1'b1;
            scnt_nx  = 3'd0;
            st_nx    = (st == RING || st == SNOOZE) ? ARMED : st;
         end else
            err_nx = 1'b1;
      end else begin
         case (st)
            IDLE:   st_nx = alarm_on ? ARMED : IDLE;
            ARMED:  if (hit) begin
                       st_nx   = RING;
                       ring_nx = 8'd0;
                    end
            RING:   if (stop) begin
                       st_nx   = ARMED;
                       scnt_nx = 3'd0;
                    end else if (snooze && snooze_cnt < 3'(MAX_SNOOZE)) begin
                       snooze_nx = snooze_calc;
                       scnt_nx   = snooze_cnt + 3'd1;
                       eqp_nx    = 1'b1;
                       st_nx     = SNOOZE;
                    end else if (tick) begin
                       if (ring_cnt == 8'(RING_TICKS - 1)) begin
                          st_nx   = ARMED;
                          scnt_nx = 3'd0;
                       end else
                          ring_nx = ring_cnt + 8'd1;
                    end
            default: if (stop) begin
                       st_nx   = ARMED;
                       scnt_nx = 3'd0;
                    end else if (hit) begin
                       st_nx   = RING;
                       ring_nx = 8'd0;
                    end
         endcase
      end
      if (!alarm_on) begin
         st_nx   = IDLE;
         ring_nx = 8'd0;
         scnt_nx = 3'd0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st          <= IDLE;
         alarm_time  <= 13'd0;
         snooze_time <= 13'd0;
         ring_cnt    <= 8'd0;
         snooze_cnt  <= 3'd0;
         eq_prev     <= 1'b1;
         set_err     <= 1'b0;
      end else begin
         st          <= st_nx;
         alarm_time  <= alarm_nx;
         snooze_time <= snooze_nx;
         ring_cnt    <= ring_nx;
         snooze_cnt  <= scnt_nx;
         eq_prev     <= eqp_nx;
         set_err     <= err_nx;
      end
   end
   assign state   = st;
   assign ringing = st == RING;
   assign snoozed = st == SNOOZE;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed-vector bench for alarm_controller with default parameters
module tb_alarm_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] time_now = 13'd0;
   logic        tick = 1'b0, alarm_on = 1'b0, set_alarm = 1'b0, snooze = 1'b0, stop = 1'b0;
   logic [12:0] set_value = 13'd0;
   logic [12:0] alarm_time;
   logic        ringing, snoozed, set_err;
   logic [1:0]  state;
   int          checks = 0, errors = 0;
   alarm_controller dut (
      .clk(clk), .rst(rst), .time_now(time_now), .tick(tick), .alarm_on(alarm_on),
      .set_alarm(set_alarm), .set_value(set_value), .snooze(snooze), .stop(stop),
      .alarm_time(alarm_time), .ringing(ringing), .snoozed(snoozed), .set_err(set_err),
      .state(state)
   );
   always #5 clk = ~clk;
   function automatic logic [12:0] bcd(input int h, input int m);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic load(input logic [12:0] v);
      set_value = v;
      set_alarm = 1'b1;
      cyc(1);
      set_alarm = 1'b0;
   endtask
   task automatic do_snooze();
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
   endtask
   initial begin
      time_now = bcd(7, 29);
      cyc(2);
      check("rst_state", 32'(state), 32'd0);
      check("rst_alarm", 32'(alarm_time), 32'd0);
      check("rst_ring", 32'(ringing), 32'd0);
      check("rst_err", 32'(set_err), 32'd0);
      rst = 1'b1;
      alarm_on = 1'b1;
      cyc(1);
      check("armed", 32'(state), 32'd1);
      load(bcd(7, 30));
      check("load_0730", 32'(alarm_time), 32'(bcd(7, 30)));
      check("load_state", 32'(state), 32'd1);
      cyc(1);
      time_now = bcd(7, 30);
      check("pre_ring", 32'(ringing), 32'd0);
      cyc(1);
      check("ring_0730", 32'(ringing), 32'd1);
      check("ring_state", 32'(state), 32'd2);
      time_now = bcd(7, 29);
      cyc(1);
      time_now = bcd(7, 30);
      cyc(2);
      check("ring_reenter", 32'(ringing), 32'd1);
      for (int i = 0; i < 59; i++) begin
         tick = 1'b1;
         cyc(1);
         tick = 1'b0;
         cyc(1);
      end
      check("tick59_ring", 32'(ringing), 32'd1);
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      check("tick60_ring", 32'(ringing), 32'd0);
      check("tick60_state", 32'(state), 32'd1);
      cyc(2);
      check("no_refire", 32'(state), 32'd1);
      time_now = bcd(23, 56);
      load(bcd(23, 57));
      cyc(1);
      time_now = bcd(23, 57);
      cyc(1);
      check("ring_2357", 32'(ringing), 32'd1);
      do_snooze();
      check("snz1_snoozed", 32'(snoozed), 32'd1);
      check("snz1_ring", 32'(ringing), 32'd0);
      time_now = bcd(0, 1);
      cyc(1);
      check("snz_wait", 32'(state), 32'd3);
      time_now = bcd(0, 2);
      cyc(1);
      check("ring_0002", 32'(ringing), 32'd1);
      do_snooze();
      time_now = bcd(0, 3);
      cyc(1);
      time_now = bcd(0, 7);
      cyc(1);
      check("ring_0007", 32'(state), 32'd2);
      do_snooze();
      time_now = bcd(0, 8);
      cyc(1);
      time_now = bcd(0, 12);
      cyc(1);
      check("ring_0012", 32'(state), 32'd2);
      do_snooze();
      check("snz4_ignored", 32'(ringing), 32'd1);
      check("snz4_snoozed", 32'(snoozed), 32'd0);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      check("stop_state", 32'(state), 32'd1);
      load(bcd(24, 0));
      check("err_2400", 32'(set_err), 32'd1);
      check("err_2400_keep", 32'(alarm_time), 32'(bcd(23, 57)));
      cyc(1);
      check("err_pulse_end", 32'(set_err), 32'd0);
      load(bcd(23, 60));
      check("err_2360", 32'(set_err), 32'd1);
      check("err_2360_keep", 32'(alarm_time), 32'(bcd(23, 57)));
      load(bcd(23, 59));
      check("ok_2359_err", 32'(set_err), 32'd0);
      check("ok_2359", 32'(alarm_time), 32'(bcd(23, 59)));
      alarm_on = 1'b0;
      cyc(1);
      check("off_idle", 32'(state), 32'd0);
      time_now = bcd(23, 59);
      cyc(1);
      alarm_on = 1'b1;
      cyc(4);
      check("arm_eq_noring", 32'(ringing), 32'd0);
      check("arm_eq_state", 32'(state), 32'd1);
      time_now = bcd(0, 0);
      cyc(1);
      time_now = bcd(23, 59);
      cyc(1);
      check("arm_eq_reenter", 32'(ringing), 32'd1);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      time_now = bcd(10, 0);
      load(bcd(10, 0));
      cyc(3);
      check("load_eq_noring", 32'(ringing), 32'd0);
      time_now = bcd(10, 1);
      cyc(1);
      time_now = bcd(10, 0);
      cyc(1);
      check("load_eq_reenter", 32'(ringing), 32'd1);
      alarm_on = 1'b0;
      cyc(1);
      check("drop_on_state", 32'(state), 32'd0);
      check("drop_on_ring", 32'(ringing), 32'd0);
      alarm_on = 1'b1;
      cyc(1);
      time_now = bcd(10, 1);
      cyc(1);
      time_now = bcd(10, 0);
      cyc(1);
      check("rering", 32'(ringing), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_ring", 32'(ringing), 32'd0);
      check("async_state", 32'(state), 32'd0);
      check("async_alarm", 32'(alarm_time), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
